// File: rtl/gp_bram_pkg.sv
// ---------------------------------------------------------------------------
// gp_bram_pkg
// Shared constants and types for the BRAM stream reader:
//   DATA_W    - BRAM word width (32-bit words)
//   BYTE_EN_W - BRAM byte write-enable width
//   ADDR_STEP - byte increment between consecutive words
//   state_t   - reader FSM states
//   clog2     - ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package gp_bram_pkg;

    localparam int          DATA_W    = 32;
    localparam int          BYTE_EN_W = 4;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// ---------------------------------------------------------------------------
// bram_rd_fifo
// Synchronous show-ahead FIFO used as the output buffer of the stream reader.
// rd_data always presents the head entry; rd_en pops it.
// Ports:
//   clka, rsta        - clock, synchronous active-high reset
//   wr_en, wr_data    - push one entry (caller guarantees not full)
//   rd_en, rd_data    - pop head entry / head entry
//   count, empty      - occupancy and empty flag
// DEPTH must be a power of 2 and at least 2.
// ---------------------------------------------------------------------------
module bram_rd_fifo
    import gp_bram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic                   clka,
    input  logic                   rsta,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [clog2(DEPTH):0]  count,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign empty   = (count == '0);
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clka) begin
        if (rsta) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries data only; it needs no reset because count gates it.
    always_ff @(posedge clka) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Fetches len_words consecutive 32-bit words from a BRAM native port starting
// at base_addr (word aligned) and replays them in order on a valid/ready
// stream. Reads are only issued when the output FIFO is guaranteed a slot, so
// BRAM latency is absorbed without overflow or loss.
// Ports:
//   clka, rsta                - clock, synchronous active-high reset
//   start, base_addr, len_words - transfer request (sampled when idle)
//   busy, done                - transfer in progress / one-cycle completion
//   bram_en, bram_we, bram_addr, bram_dout - BRAM native read port
//   m_data, m_valid, m_ready  - output stream
//   m_last                    - final-word marker (BRAM_STREAM_LAST_EN only)
// Optional feature macro: BRAM_STREAM_LAST_EN adds m_last and widens the FIFO
// to carry {last, data}.
// ---------------------------------------------------------------------------
module bram_stream_reader
    import gp_bram_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_W        = 16
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [LEN_W-1:0]     len_words,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_en,
    output logic [BYTE_EN_W-1:0] bram_we,
    output logic [31:0]          bram_addr,
    input  logic [DATA_W-1:0]    bram_dout,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_valid,
`ifdef BRAM_STREAM_LAST_EN
    output logic                 m_last,
`endif
    input  logic                 m_ready
);

    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
`ifdef BRAM_STREAM_LAST_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    state_t                  state, state_nxt;
    logic [31:0]             cur_addr;
    logic [LEN_W-1:0]        remaining;
    logic [CNT_W-1:0]        inflight;
    logic [READ_LATENCY-1:0] vld_p;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [FIFO_W-1:0]       fifo_wdata;
    logic [FIFO_W-1:0]       fifo_head;
    logic                    issue;
    logic                    wr_tag;
    logic                    pop;
    logic [CNT_W:0]          occupancy;
    logic [CNT_W:0]          credit_lim;

    assign pop        = m_valid && m_ready;
    assign wr_tag     = vld_p[READ_LATENCY-1];
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    // A slot being popped this cycle is free again by the time the new read
    // lands, so counting it keeps one word per cycle at READ_LATENCY+1 depth.
    assign credit_lim = DEPTH_C + {{CNT_W{1'b0}}, pop};
    assign issue      = (state == RUN) && (remaining != '0) && (occupancy < credit_lim);

    assign bram_en   = issue;
    assign bram_we   = '0;
    assign bram_addr = cur_addr;
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

    // Control FSM state register
    always_ff @(posedge clka) begin
        if (rsta) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (len_words == '0) ? FINISH : RUN;
            end
            RUN: begin
                if (issue && (remaining == LEN_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Leave on the edge that pops the final word so done follows
                // the last handshake by exactly one cycle.
                if ((inflight == '0) &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)))
                    state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage: address and remaining-count bookkeeping
    always_ff @(posedge clka) begin
        if (rsta) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && start) begin
            cur_addr  <= base_addr & ~32'h3;
            remaining <= len_words;
        end else if (issue) begin
            cur_addr  <= cur_addr + ADDR_STEP;
            remaining <= remaining - LEN_W'(1);
        end
    end

    // BRAM latency stage: tags follow each read until its data is valid
    always_ff @(posedge clka) begin
        if (rsta) begin
            vld_p    <= '0;
            inflight <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            unique case ({issue, wr_tag})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef BRAM_STREAM_LAST_EN
    logic [READ_LATENCY-1:0] last_p;

    always_ff @(posedge clka) begin
        if (rsta) begin
            last_p <= '0;
        end else begin
            last_p[0] <= issue && (remaining == LEN_W'(1));
            for (int i = 1; i < READ_LATENCY; i++) last_p[i] <= last_p[i-1];
        end
    end

    assign fifo_wdata = {last_p[READ_LATENCY-1], bram_dout};
    assign m_last     = m_valid && fifo_head[DATA_W];
`else
    assign fifo_wdata = bram_dout;
`endif

    // Output buffer stage
    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clka    (clka),
        .rsta    (rsta),
        .wr_en   (wr_tag),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

endmodule
